// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: instruction
// width, PC reset value, NOP encoding and the responder FSM state type.
package imem_responder_pkg;

  localparam int          IMEM_INST_WIDTH = 32;
  localparam logic [63:0] PC_RESET_VAL    = 64'h8000_0000;
  localparam logic [31:0] NOP_INST        = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // True when a byte address is word aligned.
  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response bus between the fetch stage (master) and the
// instruction memory responder (slave).
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. Once valid is raised, the source holds valid and its payload
// (req_addr, or rsp_inst/rsp_err) stable until that edge. ready may be
// raised or lowered freely and never depends on a future edge.
interface imem_responder_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int INST_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [INST_WIDTH-1:0] rsp_inst;
  logic                  rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_inst, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_inst, rsp_err
  );
endinterface

// File: rtl/imem_array.sv
// Instruction word storage: one synchronous write port and one registered
// read port. A write and read to the same index on one edge returns the new
// word (write-first). The storage itself is not reset; only the read register.
module imem_array #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] ridx,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Preload write port.
  always_ff @(posedge clk) begin
    if (we) mem[ridx == widx ? widx : widx] <= wdata;
  end

  // Registered read with bypass of a same-edge write to the same word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (we && (widx == ridx)) ? wdata : mem[ridx];
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one fetch at a time, waits
// WAIT_CYCLES, then presents the instruction word (or NOP with rsp_err for a
// misaligned / out-of-range fetch) until the fetch stage takes it.
// Optional build macro: IMEM_RESP_STATS_EN adds fetch and error counters.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 64,
  parameter int                    INST_WIDTH  = IMEM_INST_WIDTH,
  parameter int                    DEPTH       = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = PC_RESET_VAL,
  parameter int unsigned           WAIT_CYCLES = 1,
  localparam int                   IDX_W       = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  imem_responder_if.slave       bus,
  input  logic                  load_en,
  input  logic [IDX_W-1:0]      load_idx,
  input  logic [INST_WIDTH-1:0] load_data,
  output state_t                dbg_state
`ifdef IMEM_RESP_STATS_EN
  ,
  output logic [31:0]           stat_fetch_cnt,
  output logic [31:0]           stat_err_cnt
`endif
);

  localparam int CNT_W = 4;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    err_q;
  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   offset;
  logic                    dec_err;
  logic [IDX_W-1:0]        rd_idx;
  logic [INST_WIDTH-1:0]   rd_data;

  // Address decode of the latched request; unsigned full-width arithmetic.
  assign offset  = addr_q - BASE_ADDR;
  assign dec_err = !word_aligned(addr_q[1:0]) || (addr_q < BASE_ADDR) ||
                   ((offset >> 2) >= ADDR_WIDTH'(DEPTH));
  assign rd_idx  = offset[IDX_W+1:2];

  // State register plus request latch, wait counter and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q <= bus.req_addr;
            cnt    <= CNT_W'(WAIT_CYCLES);
          end
        end
        WAIT: begin
          if (cnt == '0) err_q <= dec_err;
          else           cnt   <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic and array read enable.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      IDLE: if (bus.req_valid) state_nxt = WAIT;
      WAIT: begin
        if (cnt == '0) begin
          state_nxt = RESP;
          rd_en     = !dec_err;
        end
      end
      RESP: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  imem_array #(
    .DEPTH (DEPTH),
    .WIDTH (INST_WIDTH)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (load_en),
    .widx  (load_idx),
    .wdata (load_data),
    .re    (rd_en),
    .ridx  (rd_idx),
    .rdata (rd_data)
  );

  // Both the error flag and the read register only change on the read edge,
  // so the response stays stable for as long as RESP is stalled.
  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_err   = err_q;
  assign bus.rsp_inst  = err_q ? INST_WIDTH'(NOP_INST) : rd_data;
  assign dbg_state     = state;

`ifdef IMEM_RESP_STATS_EN
  // Completed-response and error-response counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fetch_cnt <= '0;
      stat_err_cnt   <= '0;
    end else if (bus.rsp_valid && bus.rsp_ready) begin
      stat_fetch_cnt <= stat_fetch_cnt + 32'd1;
      if (err_q) stat_err_cnt <= stat_err_cnt + 32'd1;
    end
  end
`endif

endmodule
